// File: rtl/armv8_pkg.sv
// Shared ARMv8 datapath definitions.
// Holds the default datapath widths, the data-memory access FSM encoding and
// the bit positions of the EX control bundle. The decoder, the ID/EX stage and
// the EX/MEM stage all use the same bundle layout.
package armv8_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_REG_W    = 5;
  localparam int DEF_MAX_WAIT = 15;

  // Wait counter width; covers MAX_WAIT up to 255.
  localparam int WAIT_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // Control bundle bit positions.
  localparam int CTL_MEMREAD  = 0;
  localparam int CTL_MEMWRITE = 1;
  localparam int CTL_REGWRITE = 2;
  localparam int CTL_MEMTOREG = 3;
  localparam int CTL_BRANCH   = 4;
  localparam int CTL_UNCOND   = 5;
  localparam int CTL_W        = 6;

  // The bundle needs a data-memory access.
  function automatic logic is_mem_op(input logic [CTL_W-1:0] ctl);
    return ctl[CTL_MEMREAD] | ctl[CTL_MEMWRITE];
  endfunction

  // B is always taken; CBZ is taken when the ALU result was zero.
  function automatic logic branch_taken(input logic [CTL_W-1:0] ctl, input logic zero);
    return ctl[CTL_UNCOND] | (ctl[CTL_BRANCH] & zero);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer for the EX/MEM stage.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_start          a valid LDUR/STUR is being captured this edge
//   i_mem_ack        memory completes the access this cycle
//   o_mem_req        request is outstanding (state ACCESS)
//   o_stall          upstream must hold (ACCESS without ack)
//   o_mem_timeout    one-cycle pulse after an aborted access
//   o_done           access completes on this edge
//   o_abort          access is abandoned on this edge
module mem_access_fsm
  import armv8_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_mem_ack,
  output logic o_mem_req,
  output logic o_stall,
  output logic o_mem_timeout,
  output logic o_done,
  output logic o_abort
);

  // The counter holds the number of ACCESS cycles already spent without ack,
  // so the abort edge is the one where it would step onto MAX_WAIT.
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);

  mem_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  assign o_mem_req     = (state_q == ST_ACCESS);
  assign o_stall       = o_mem_req & ~i_mem_ack;
  assign o_done        = o_mem_req & i_mem_ack;
  assign o_abort       = o_stall & (cnt_q == LAST_WAIT);
  assign o_mem_timeout = timeout_q;

  // Next-state, wait counter and timeout pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_start) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (i_mem_ack) begin
          // A mem op captured on the ack edge chains straight into a new access.
          state_d = i_start ? ST_ACCESS : ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_WAIT) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage of the ARMv8 datapath.
// Captures the ALU result and EX control bits whenever the stage is not
// stalled, resolves CBZ/B into a one-cycle PC-select pulse, runs a req/ack
// data-memory access for LDUR/STUR and presents the MEM/WB register.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_valid, i_flush              incoming instruction valid / squash
//   i_ALURes, i_ZERO              ALU result and zero flag
//   i_store_data, i_branch_target Rt value for STUR, PC+offset
//   i_rd, i_MemRead..i_UncondBranch  destination and EX control bits
//   o_stall                       hold PC/IF/ID/EX
//   o_PCSrc, o_branch_target      take-branch pulse and registered target
//   o_mem_req/we/addr/wdata       memory request side
//   i_mem_ack, i_mem_rdata        memory response side
//   o_mem_timeout                 pulse after an abandoned access
//   o_wb_valid/RegWrite/rd/data   MEM/WB register
module ex_mem_stage
  import armv8_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_ALURes,
  input  logic              i_ZERO,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_branch_target,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic              i_RegWrite,
  input  logic              i_MemtoReg,
  input  logic              i_Branch,
  input  logic              i_UncondBranch,
  output logic              o_stall,
  output logic              o_PCSrc,
  output logic [DATA_W-1:0] o_branch_target,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_timeout,
  output logic              o_wb_valid,
  output logic              o_wb_RegWrite,
  output logic [REG_W-1:0]  o_wb_rd,
  output logic [DATA_W-1:0] o_wb_data
);

  // Stage register
  logic              valid_q, valid_d;
  logic [CTL_W-1:0]  ctl_q, ctl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  // MEM/WB register
  logic              wb_valid_q, wb_valid_d;
  logic              wb_rw_q, wb_rw_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic             stall_s, req_s, done_s, abort_s, capture_s, in_valid_s, start_s;
  logic [CTL_W-1:0] in_ctl_s;

  assign capture_s  = ~stall_s;
  assign in_valid_s = i_valid & ~i_flush;
  assign start_s    = capture_s & is_mem_op(in_ctl_s);

  // Incoming control bundle; a bubble carries no control bits at all.
  always_comb begin
    in_ctl_s               = '0;
    in_ctl_s[CTL_MEMREAD]  = i_MemRead & in_valid_s;
    in_ctl_s[CTL_MEMWRITE] = i_MemWrite & in_valid_s;
    in_ctl_s[CTL_REGWRITE] = i_RegWrite & in_valid_s;
    in_ctl_s[CTL_MEMTOREG] = i_MemtoReg & in_valid_s;
    in_ctl_s[CTL_BRANCH]   = i_Branch & in_valid_s;
    in_ctl_s[CTL_UNCOND]   = i_UncondBranch & in_valid_s;
  end

  mem_access_fsm #(
    .MAX_WAIT(MAX_WAIT)
  ) u_fsm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (start_s),
    .i_mem_ack    (i_mem_ack),
    .o_mem_req    (req_s),
    .o_stall      (stall_s),
    .o_mem_timeout(o_mem_timeout),
    .o_done       (done_s),
    .o_abort      (abort_s)
  );

  // Stage and MEM/WB next-state.
  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    alu_d   = alu_q;
    sdata_d = sdata_q;
    rd_d    = rd_q;
    tgt_d   = tgt_q;
    pcsrc_d = 1'b0;
    if (capture_s) begin
      valid_d = in_valid_s;
      ctl_d   = in_ctl_s;
      alu_d   = i_ALURes;
      sdata_d = i_store_data;
      rd_d    = i_rd;
      tgt_d   = i_branch_target;
      pcsrc_d = branch_taken(in_ctl_s, i_ZERO);
    end else if (abort_s) begin
      // Drop the abandoned op so it never reaches WB once the stall lifts.
      valid_d = 1'b0;
      ctl_d   = '0;
    end else begin
      pcsrc_d = 1'b0;
    end
    // The stage instruction completes on any unstalled edge: immediately for
    // non-mem ops (FSM idle) and on the ack edge for mem ops.
    wb_valid_d = valid_q & (done_s | ~req_s);
    wb_rw_d    = wb_valid_d & ctl_q[CTL_REGWRITE];
    wb_rd_d    = rd_q;
    wb_data_d  = ctl_q[CTL_MEMTOREG] ? i_mem_rdata : alu_q;
  end

  // Stage, branch and MEM/WB registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      ctl_q      <= '0;
      alu_q      <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      pcsrc_q    <= 1'b0;
      tgt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      ctl_q      <= ctl_d;
      alu_q      <= alu_d;
      sdata_q    <= sdata_d;
      rd_q       <= rd_d;
      pcsrc_q    <= pcsrc_d;
      tgt_q      <= tgt_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign o_stall         = stall_s;
  assign o_PCSrc         = pcsrc_q;
  assign o_branch_target = tgt_q;
  assign o_mem_req       = req_s;
  assign o_mem_we        = req_s & ctl_q[CTL_MEMWRITE];
  assign o_mem_addr      = alu_q;
  assign o_mem_wdata     = sdata_q;
  assign o_wb_valid      = wb_valid_q;
  assign o_wb_RegWrite   = wb_rw_q;
  assign o_wb_rd         = wb_rd_q;
  assign o_wb_data       = wb_data_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int K_NONE = 0, K_ADD = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_B = 5;

  logic        i_clk, i_rst, i_valid, i_flush, i_ZERO;
  logic [63:0] i_ALURes, i_store_data, i_branch_target, i_mem_rdata;
  logic [4:0]  i_rd;
  logic        i_MemRead, i_MemWrite, i_RegWrite, i_MemtoReg, i_Branch, i_UncondBranch;
  logic        i_mem_ack;
  logic        o_stall, o_PCSrc, o_mem_req, o_mem_we, o_mem_timeout, o_wb_valid, o_wb_RegWrite;
  logic [63:0] o_branch_target, o_mem_addr, o_mem_wdata, o_wb_data;
  logic [4:0]  o_wb_rd;

  int checks = 0;
  int errors = 0;

  ex_mem_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_ALURes(i_ALURes), .i_ZERO(i_ZERO), .i_store_data(i_store_data),
    .i_branch_target(i_branch_target), .i_rd(i_rd),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite),
    .i_MemtoReg(i_MemtoReg), .i_Branch(i_Branch), .i_UncondBranch(i_UncondBranch),
    .o_stall(o_stall), .o_PCSrc(o_PCSrc), .o_branch_target(o_branch_target),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_mem_timeout(o_mem_timeout), .o_wb_valid(o_wb_valid),
    .o_wb_RegWrite(o_wb_RegWrite), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one instruction of the given kind on the EX side.
  task automatic set_op(input int kind, input logic v, input logic f, input logic [63:0] a,
                        input logic [63:0] sd, input logic [63:0] t, input logic [4:0] r,
                        input logic z);
    i_valid = v; i_flush = f; i_ALURes = a; i_store_data = sd; i_branch_target = t;
    i_rd = r; i_ZERO = z;
    i_MemRead = (kind == K_LD); i_MemWrite = (kind == K_ST);
    i_RegWrite = (kind == K_ADD) || (kind == K_LD); i_MemtoReg = (kind == K_LD);
    i_Branch = (kind == K_CBZ); i_UncondBranch = (kind == K_B);
  endtask

  task automatic bubble();
    set_op(K_NONE, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 64'h0; bubble();
    #2 i_rst = 1'b1;
    #2;
    checks++; if ({o_stall, o_PCSrc, o_mem_req, o_mem_we, o_mem_timeout, o_wb_valid, o_wb_RegWrite} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 0", {o_stall, o_PCSrc, o_mem_req, o_mem_we, o_mem_timeout, o_wb_valid, o_wb_RegWrite}); end
    checks++; if ({o_branch_target, o_mem_addr, o_mem_wdata, o_wb_data, o_wb_rd} !== 261'b0) begin
      errors++; $display("FAIL reset_data got nonzero data outputs"); end
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_add();
    int stalls = 0;
    set_op(K_ADD, 1'b1, 1'b0, 64'h2A, 64'h0, 64'h0, 5'd3, 1'b0);
    tick();
    if (o_stall) stalls++;
    bubble();
    tick();
    if (o_stall) stalls++;
    checks++; if (o_wb_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", o_wb_valid); end
    checks++; if (o_wb_rd !== 5'd3) begin errors++; $display("FAIL add_rd got %0d exp 3", o_wb_rd); end
    checks++; if (o_wb_data !== 64'h2A) begin errors++; $display("FAIL add_data got %h exp 2a", o_wb_data); end
    checks++; if (o_wb_RegWrite !== 1'b1) begin errors++; $display("FAIL add_rw got %b exp 1", o_wb_RegWrite); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL add_stall got %0d exp 0", stalls); end
    tick();
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL add_idle_wb got %b exp 0", o_wb_valid); end
  endtask

  task automatic test_branch();
    set_op(K_CBZ, 1'b1, 1'b0, 64'h0, 64'h0, 64'h400, 5'd0, 1'b1);
    tick();
    bubble();
    checks++; if (o_PCSrc !== 1'b1) begin errors++; $display("FAIL cbz_taken got %b exp 1", o_PCSrc); end
    checks++; if (o_branch_target !== 64'h400) begin errors++; $display("FAIL cbz_target got %h exp 400", o_branch_target); end
    tick();
    checks++; if (o_PCSrc !== 1'b0) begin errors++; $display("FAIL cbz_pulse got %b exp 0", o_PCSrc); end
    set_op(K_CBZ, 1'b1, 1'b0, 64'h5, 64'h0, 64'h400, 5'd0, 1'b0);
    tick();
    bubble();
    checks++; if (o_PCSrc !== 1'b0) begin errors++; $display("FAIL cbz_not_taken got %b exp 0", o_PCSrc); end
    tick();
  endtask

  task automatic test_load_wait();
    int reqs = 0, stalls = 0;
    set_op(K_LD, 1'b1, 1'b0, 64'h1000, 64'h0, 64'h0, 5'd7, 1'b0);
    tick();
    bubble();
    for (int c = 0; c < 4; c++) begin
      i_mem_ack = (c == 3);
      i_mem_rdata = (c == 3) ? 64'hDEAD_BEEF : 64'h0BAD;
      #1;
      if (o_mem_req) reqs++;
      if (o_stall) stalls++;
      if (c == 0) begin
        checks++; if ({o_mem_addr, o_mem_we} !== {64'h1000, 1'b0}) begin
          errors++; $display("FAIL ld_req got addr %h we %b exp 1000 0", o_mem_addr, o_mem_we); end
      end
      tick();
    end
    i_mem_ack = 1'b0;
    checks++; if (reqs != 4) begin errors++; $display("FAIL ld_req_cycles got %0d exp 4", reqs); end
    checks++; if (stalls != 3) begin errors++; $display("FAIL ld_stall_cycles got %0d exp 3", stalls); end
    checks++; if (o_wb_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL ld_data got %h exp deadbeef", o_wb_data); end
    checks++; if ({o_wb_valid, o_wb_RegWrite, o_wb_rd} !== {1'b1, 1'b1, 5'd7}) begin
      errors++; $display("FAIL ld_wb got v%b rw%b rd%0d exp v1 rw1 rd7", o_wb_valid, o_wb_RegWrite, o_wb_rd); end
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL ld_idle got %b exp 0", o_mem_req); end
  endtask

  task automatic test_store_zero_wait();
    set_op(K_ST, 1'b1, 1'b0, 64'h2008, 64'h55, 64'h0, 5'd1, 1'b0);
    tick();
    bubble();
    i_mem_ack = 1'b1;
    #1;
    checks++; if ({o_mem_req, o_mem_we, o_stall} !== 3'b110) begin
      errors++; $display("FAIL st_req got req%b we%b stall%b exp 1 1 0", o_mem_req, o_mem_we, o_stall); end
    checks++; if ({o_mem_addr, o_mem_wdata} !== {64'h2008, 64'h55}) begin
      errors++; $display("FAIL st_bus got %h %h exp 2008 55", o_mem_addr, o_mem_wdata); end
    tick();
    i_mem_ack = 1'b0;
    checks++; if ({o_wb_valid, o_wb_RegWrite} !== 2'b10) begin
      errors++; $display("FAIL st_wb got %b%b exp 10", o_wb_valid, o_wb_RegWrite); end
  endtask

  task automatic test_timeout();
    int reqs = 0, stalls = 0, tos = 0, to_at = -1, wbs = 0;
    set_op(K_LD, 1'b1, 1'b0, 64'h3300, 64'h0, 64'h0, 5'd2, 1'b0);
    tick();
    bubble();
    for (int c = 0; c < 20; c++) begin
      #1;
      if (o_mem_req) reqs++;
      if (o_stall) stalls++;
      if (o_mem_timeout) begin tos++; to_at = c; end
      if (o_wb_valid) wbs++;
      tick();
    end
    checks++; if (reqs != 15) begin errors++; $display("FAIL to_req got %0d exp 15", reqs); end
    checks++; if (stalls != 15) begin errors++; $display("FAIL to_stall got %0d exp 15", stalls); end
    checks++; if (tos != 1 || to_at != 15) begin errors++; $display("FAIL to_pulse got %0d at %0d exp 1 at 15", tos, to_at); end
    checks++; if (wbs != 0) begin errors++; $display("FAIL to_wb got %0d exp 0", wbs); end
    set_op(K_ADD, 1'b1, 1'b0, 64'h99, 64'h0, 64'h0, 5'd5, 1'b0);
    tick();
    bubble();
    tick();
    checks++; if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, 5'd5, 64'h99}) begin
      errors++; $display("FAIL to_next_add got v%b rd%0d %h exp v1 rd5 99", o_wb_valid, o_wb_rd, o_wb_data); end
  endtask

  task automatic test_async_reset_flush();
    set_op(K_LD, 1'b1, 1'b0, 64'h4000, 64'h0, 64'h0, 5'd6, 1'b0);
    tick();
    bubble();
    #2;
    checks++; if ({o_mem_req, o_stall} !== 2'b11) begin errors++; $display("FAIL rst_pre got %b exp 11", {o_mem_req, o_stall}); end
    i_rst = 1'b1;
    #1;
    checks++; if ({o_mem_req, o_stall, o_wb_valid, o_mem_timeout} !== 4'b0) begin
      errors++; $display("FAIL rst_async got %b exp 0000", {o_mem_req, o_stall, o_wb_valid, o_mem_timeout}); end
    #2 i_rst = 1'b0;
    tick();
    checks++; if ({o_mem_req, o_wb_valid} !== 2'b00) begin errors++; $display("FAIL rst_after got %b exp 00", {o_mem_req, o_wb_valid}); end
    set_op(K_LD, 1'b1, 1'b1, 64'h5000, 64'h0, 64'h0, 5'd8, 1'b0);
    tick();
    bubble();
    checks++; if ({o_mem_req, o_stall} !== 2'b00) begin errors++; $display("FAIL flush_req got %b exp 00", {o_mem_req, o_stall}); end
    tick();
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb got %b exp 0", o_wb_valid); end
  endtask

  task automatic test_back_to_back();
    set_op(K_LD, 1'b1, 1'b0, 64'h3000, 64'h0, 64'h0, 5'd4, 1'b0);
    tick();
    // A taken CBZ waits behind the load.
    set_op(K_CBZ, 1'b1, 1'b0, 64'h0, 64'h0, 64'h800, 5'd0, 1'b1);
    #1;
    checks++; if ({o_stall, o_PCSrc, o_mem_addr} !== {1'b1, 1'b0, 64'h3000}) begin
      errors++; $display("FAIL b2b_hold got stall%b pc%b %h exp 1 0 3000", o_stall, o_PCSrc, o_mem_addr); end
    tick();
    checks++; if (o_PCSrc !== 1'b0) begin errors++; $display("FAIL b2b_no_pc_stall got %b exp 0", o_PCSrc); end
    i_mem_ack = 1'b1; i_mem_rdata = 64'h1111;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL b2b_ack_stall got %b exp 0", o_stall); end
    tick();
    i_mem_ack = 1'b0;
    checks++; if ({o_PCSrc, o_branch_target} !== {1'b1, 64'h800}) begin
      errors++; $display("FAIL b2b_branch got %b %h exp 1 800", o_PCSrc, o_branch_target); end
    checks++; if ({o_wb_valid, o_wb_RegWrite, o_wb_rd, o_wb_data} !== {2'b11, 5'd4, 64'h1111}) begin
      errors++; $display("FAIL b2b_ld_wb got %b%b rd%0d %h exp 11 rd4 1111", o_wb_valid, o_wb_RegWrite, o_wb_rd, o_wb_data); end
    set_op(K_ST, 1'b1, 1'b0, 64'h40, 64'h77, 64'h0, 5'd0, 1'b0);
    tick();
    checks++; if ({o_PCSrc, o_wb_valid, o_wb_RegWrite} !== 3'b010) begin
      errors++; $display("FAIL b2b_cbz_wb got %b exp 010", {o_PCSrc, o_wb_valid, o_wb_RegWrite}); end
    set_op(K_LD, 1'b1, 1'b0, 64'h48, 64'h0, 64'h0, 5'd9, 1'b0);
    i_mem_ack = 1'b1;
    #1;
    checks++; if ({o_mem_addr, o_mem_wdata, o_mem_we, o_stall} !== {64'h40, 64'h77, 2'b10}) begin
      errors++; $display("FAIL b2b_st_bus got %h %h we%b st%b exp 40 77 1 0", o_mem_addr, o_mem_wdata, o_mem_we, o_stall); end
    tick();
    i_mem_ack = 1'b0;
    checks++; if ({o_wb_valid, o_wb_RegWrite, o_mem_req, o_mem_we, o_mem_addr} !== {4'b1010, 64'h48}) begin
      errors++; $display("FAIL b2b_chain got %b %h exp 1010 48", {o_wb_valid, o_wb_RegWrite, o_mem_req, o_mem_we}, o_mem_addr); end
    bubble();
    i_mem_ack = 1'b1; i_mem_rdata = 64'hABCD;
    tick();
    i_mem_ack = 1'b0;
    checks++; if ({o_wb_valid, o_wb_RegWrite, o_wb_rd, o_wb_data, o_mem_req} !== {2'b11, 5'd9, 64'hABCD, 1'b0}) begin
      errors++; $display("FAIL b2b_ld2 got rd%0d %h req%b exp rd9 abcd 0", o_wb_rd, o_wb_data, o_mem_req); end
  endtask

  // Random single instructions checked against spec-level expectations.
  task automatic test_random();
    int kind, wt;
    logic v, f, z, ev, e_mem, e_pc, e_rw, e_we;
    logic [63:0] a, sd, t, md, e_data;
    logic [4:0] r;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(5, 1));
      v = ($urandom_range(9, 0) != 0);
      f = ($urandom_range(7, 0) == 0);
      a = {$urandom, $urandom}; sd = {$urandom, $urandom}; t = {$urandom, $urandom};
      md = {$urandom, $urandom};
      r = 5'($urandom_range(31, 0));
      z = 1'($urandom_range(1, 0));
      ev    = v & ~f;
      e_mem = ev & (kind == K_LD || kind == K_ST);
      e_pc  = ev & (kind == K_B || (kind == K_CBZ && z));
      e_rw  = ev & (kind == K_ADD || kind == K_LD);
      e_we  = (kind == K_ST);
      e_data = (kind == K_LD) ? md : a;
      set_op(kind, v, f, a, sd, t, r, z);
      tick();
      bubble();
      checks++; if (o_PCSrc !== e_pc) begin errors++; $display("FAIL rnd_pcsrc it%0d got %b exp %b", it, o_PCSrc, e_pc); end
      if (e_pc) begin
        checks++; if (o_branch_target !== t) begin errors++; $display("FAIL rnd_target it%0d got %h exp %h", it, o_branch_target, t); end
      end
      if (e_mem) begin
        wt = int'($urandom_range(4, 0));
        for (int c = 0; c <= wt; c++) begin
          i_mem_ack = (c == wt);
          i_mem_rdata = (c == wt) ? md : {$urandom, $urandom};
          #1;
          checks++; if ({o_mem_req, o_mem_we, o_mem_addr, o_stall} !== {1'b1, e_we, a, (c != wt)}) begin
            errors++; $display("FAIL rnd_access it%0d c%0d got req%b we%b %h st%b exp we%b %h", it, c, o_mem_req, o_mem_we, o_mem_addr, o_stall, e_we, a); end
          if (e_we) begin
            checks++; if (o_mem_wdata !== sd) begin errors++; $display("FAIL rnd_wdata it%0d got %h exp %h", it, o_mem_wdata, sd); end
          end
          tick();
        end
        i_mem_ack = 1'b0;
      end else begin
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rnd_noreq it%0d got %b exp 0", it, o_mem_req); end
        tick();
      end
      checks++; if (o_wb_valid !== ev) begin errors++; $display("FAIL rnd_wb_valid it%0d got %b exp %b", it, o_wb_valid, ev); end
      if (ev) begin
        checks++; if ({o_wb_RegWrite, o_wb_rd, o_wb_data} !== {e_rw, r, e_data}) begin
          errors++; $display("FAIL rnd_wb it%0d got rw%b rd%0d %h exp rw%b rd%0d %h", it, o_wb_RegWrite, o_wb_rd, o_wb_data, e_rw, r, e_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load_wait();
    test_store_zero_wait();
    test_timeout();
    test_async_reset_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
